// File: rtl/halo_output_packer.sv
// halo_output_packer: compacts up to IN_LANES sparse halo products per cycle
// into a circular FIFO and emits up to 8 of the oldest entries per cycle to the
// neighbour input stage. A RUN/DRAIN/DONE FSM tracks tile completion and
// pulses drained once the tile has been fully emitted.
// Optional build macro: HALO_PACKER_STATS_EN adds the stall_cycles and
// peak_count statistics outputs.
module halo_output_packer #(
  parameter int IN_LANES   = 16,
  parameter int TILE_SIZE  = 128,
  parameter int FIFO_DEPTH = 32,
  localparam int CW        = $clog2(TILE_SIZE),
  localparam int CNTW      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          in_value  [IN_LANES],
  input  logic [CW-1:0]       in_row    [IN_LANES],
  input  logic [CW-1:0]       in_column [IN_LANES],
  input  logic [IN_LANES-1:0] in_valid,
  output logic                in_ready,
  input  logic                tile_done,
  input  logic                downstream_stall,
  output logic [7:0]          out_value  [8],
  output logic [CW-1:0]       out_row    [8],
  output logic [CW-1:0]       out_column [8],
  output logic [7:0]          out_write_enable,
  output logic [CNTW-1:0]     fifo_count,
`ifdef HALO_PACKER_STATS_EN
  output logic [15:0]         stall_cycles,
  output logic [CNTW-1:0]     peak_count,
`endif
  output logic                drained
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LIMIT = FIFO_DEPTH - IN_LANES;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_next;
  logic [CNTW-1:0] push_count, pushed, popped;
  logic [3:0]      k;
  logic [PW-1:0]   wr_addr [IN_LANES];

  // FIFO storage: deliberately not reset, contents are qualified by count
  logic [7:0]      mem_value  [FIFO_DEPTH];
  logic [CW-1:0]   mem_row    [FIFO_DEPTH];
  logic [CW-1:0]   mem_column [FIFO_DEPTH];

  assign fifo_count = count;
  assign drained    = (state == DONE);
  assign in_ready   = (state == RUN) && (count <= CNTW'(LIMIT));
  assign k          = (count > CNTW'(8)) ? 4'd8 : 4'(count);
  assign pushed     = in_ready ? push_count : '0;
  assign popped     = downstream_stall ? '0 : CNTW'(k);
  assign count_next = count + pushed - popped;

  // Prefix-count the valid lanes so each lands in the next free slot in lane order
  always_comb begin
    push_count = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      wr_addr[i] = wr_ptr + PW'(push_count);
      if (in_valid[i]) push_count = push_count + CNTW'(1);
    end
  end

  // Compacted write of accepted lanes into the circular storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_LANES; i++) begin
      if (in_ready && in_valid[i]) begin
        mem_value[wr_addr[i]]  <= in_value[i];
        mem_row[wr_addr[i]]    <= in_row[i];
        mem_column[wr_addr[i]] <= in_column[i];
      end
    end
  end

  // Head-of-FIFO output lanes; lanes beyond the available entries read as zero
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_out
      logic [PW-1:0] rd_addr;
      logic          lane_live;
      assign rd_addr    = rd_ptr + PW'(gi);
      assign lane_live  = (4'(gi) < k);
      assign out_value[gi]        = lane_live ? mem_value[rd_addr]  : '0;
      assign out_row[gi]          = lane_live ? mem_row[rd_addr]    : '0;
      assign out_column[gi]       = lane_live ? mem_column[rd_addr] : '0;
      assign out_write_enable[gi] = lane_live && !downstream_stall;
    end
  endgenerate

  // Pointer, occupancy and state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= RUN;
    end else begin
      wr_ptr <= wr_ptr + PW'(pushed);
      rd_ptr <= rd_ptr + PW'(popped);
      count  <= count_next;
      state  <= state_next;
    end
  end

  // Tile FSM: tile_done only matters in RUN; DONE lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (tile_done) state_next = DRAIN;
      DRAIN:   if (count == '0 && !downstream_stall) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

`ifdef HALO_PACKER_STATS_EN
  logic enter_done;
  assign enter_done = (state_next == DONE) && (state != DONE);

  // Statistics: saturating stall counter and occupancy high-water mark per tile
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      peak_count   <= '0;
    end else if (enter_done) begin
      stall_cycles <= '0;
      peak_count   <= '0;
    end else begin
      if (downstream_stall && count != '0 && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (count > peak_count)
        peak_count <= count;
    end
  end
`endif

endmodule
